// File: rtl/ltl_report_collector.sv
// rtl/ltl_report_collector.sv - queues non-zero LTL automaton report events tagged with their symbol index
// Optional occupancy interrupt enabled by defining LTL_RPT_COLLECTOR_IRQ_EN.
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int IDX_W       = 16,
  parameter int DEPTH       = 8,
  parameter int IRQ_THRESH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         clear,
  input  logic [NUM_REPORTS-1:0]       rpt_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W+NUM_REPORTS-1:0] out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [7:0]                   drop_cnt,
  output logic                         irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = IDX_W + NUM_REPORTS;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] sym_idx, idx_q;
  logic             run_q;
  logic [ENT_W-1:0] last_q;
  logic             ovf_q;
  logic [7:0]       drop_q;

  logic evt, full, pop, push, drop;

  // Reports lag their symbol by one cycle, so pair them with the delayed run/index.
  always_comb begin
    evt  = run_q & (|rpt_in);
    full = (cnt_q == CNT_W'(DEPTH));
    pop  = out_valid & out_ready;
    push = evt & (~full | pop);
    drop = evt & full & ~pop;
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : last_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {idx_q, rpt_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      sym_idx <= '0;
      idx_q   <= '0;
      run_q   <= 1'b0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      run_q <= run;
      idx_q <= sym_idx;
      if (run) begin
        sym_idx <= sym_idx + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 1'b1;
        end
      end
    end
  end

`ifdef LTL_RPT_COLLECTOR_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (cnt_q >= CNT_W'(IRQ_THRESH)) | ovf_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ltl_report_collector.sv
// tb/tb_ltl_report_collector.sv - scoreboard bench for ltl_report_collector
module tb_ltl_report_collector;

  logic        clk = 1'b0;
  logic        reset, run, clear, out_ready;
  logic [3:0]  rpt_in;
  logic        out_valid, overflow, irq;
  logic [19:0] out_data;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;

  ltl_report_collector dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .rpt_in(rpt_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [19:0] sb[$];
  int          m_count = 0;
  logic [15:0] m_sym = '0, m_idx_q = '0;
  logic        m_run_q = 1'b0, m_ovf = 1'b0, m_irq = 1'b0;
  int          m_drop = 0;
  logic [19:0] m_last = '0;
  logic [19:0] last_dut = '0;
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rp, input logic rdy,
                      input logic clr, input logic rst);
    logic ev, pp, ps;
    run = r; rpt_in = rp; out_ready = rdy; clear = clr; reset = rst;
    @(posedge clk);
    if (rst || clr) begin
      m_count = 0; m_sym = '0; m_idx_q = '0; m_run_q = 1'b0;
      m_ovf = 1'b0; m_drop = 0; m_irq = 1'b0; m_last = '0;
      sb.delete();
    end else begin
      ev = m_run_q && (rp != 4'b0);
      pp = rdy && (m_count > 0);
      ps = ev && ((m_count < 8) || pp);
`ifdef LTL_RPT_COLLECTOR_IRQ_EN
      m_irq = (m_count >= 4) || m_ovf;
`else
      m_irq = 1'b0;
`endif
      if (ps) sb.push_back({m_idx_q, rp});
      else if (ev) begin
        m_ovf = 1'b1;
        if (m_drop != 255) m_drop++;
      end
      m_count = m_count + int'(ps) - int'(pp);
      m_idx_q = m_sym;
      m_run_q = r;
      if (r) m_sym = m_sym + 16'd1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", 32'(out_valid), 32'(m_count != 0));
      check("count", 32'(count), 32'(m_count));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check("irq", 32'(irq), 32'(m_irq));
      if (m_count == 0) begin
        check("hold_data", 32'(out_data), 32'(m_last));
      end else if (sb.size() == 0) begin
        check("sb_empty", 32'(sb.size()), 32'(m_count));
      end else if (out_ready) begin
        m_last = sb.pop_front();
        last_dut = out_data;
        check("pop_data", 32'(out_data), 32'(m_last));
      end else begin
        check("head_data", 32'(out_data), 32'(sb[0]));
      end
    end
  end

  initial begin
    run = 0; rpt_in = '0; out_ready = 0; clear = 0; reset = 1;
    step(0, 4'h0, 0, 0, 1);
    step(0, 4'h0, 0, 0, 1);
    mon_en = 1'b1;

    // 1: single event, index 1
    step(1, 4'h0, 1, 0, 0);
    step(1, 4'h0, 1, 0, 0);
    step(1, 4'h4, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4'h0, 1, 0, 0);
    check("t1_data", 32'(last_dut), 32'({16'd1, 4'b0100}));

    // 2: overflow with 10 events, then drain
    step(0, 4'h0, 0, 1, 0);
    step(1, 4'h0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 4'h1, 0, 0, 0);
    step(0, 4'h1, 0, 0, 0);
    check("t2_count", 32'(count), 32'd8);
    check("t2_drop", 32'(drop_cnt), 32'd2);
    check("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 4'h0, 1, 0, 0);
    check("t2_last", 32'(last_dut), 32'({16'd7, 4'b0001}));

    // 3: full FIFO, push and pop together
    step(0, 4'h0, 0, 1, 0);
    step(1, 4'h0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 4'h2, 0, 0, 0);
    step(0, 4'h3, 1, 0, 0);
    check("t3_count", 32'(count), 32'd8);
    check("t3_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 4'h0, 1, 0, 0);
    check("t3_tail", 32'(last_dut), 32'({16'd8, 4'h3}));

    // 4: index wrap
    step(0, 4'h0, 1, 1, 0);
    for (int i = 0; i < 65535; i++) step(1, 4'h0, 1, 0, 0);
    step(1, 4'h0, 0, 0, 0);
    step(1, 4'h8, 0, 0, 0);
    step(0, 4'h9, 0, 0, 0);
    step(0, 4'h0, 1, 0, 0);
    check("t4_first", 32'(last_dut), 32'({16'hFFFF, 4'h8}));
    step(0, 4'h0, 1, 0, 0);
    check("t4_second", 32'(last_dut), 32'({16'h0000, 4'h9}));
    step(0, 4'h0, 1, 0, 0);

    // 5: clear and clear+reset with queued entries
    for (int k = 0; k < 2; k++) begin
      step(1, 4'h0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 4'h5, 0, 0, 0);
      step(0, 4'h0, 0, 0, 0);
      step(0, 4'h0, 1, 1, (k == 1));
      check("t5_count", 32'(count), 32'd0);
      check("t5_valid", 32'(out_valid), 32'd0);
      step(1, 4'h0, 1, 0, 0);
      step(0, 4'h6, 1, 0, 0);
      step(0, 4'h0, 1, 0, 0);
      check("t5_idx0", 32'(last_dut), 32'({16'd0, 4'h6}));
      step(0, 4'h0, 1, 1, 0);
    end

    // 6: occupancy interrupt
    step(1, 4'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 4'hA, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 0, 0, 0);
    step(0, 4'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 4'h0, 1, 0, 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
